// File: rtl/player_state.sv
// Per-player tank position, aim and projectile flight/cooldown state machine.
// Optional shot counter enabled by defining PLAYER_SHOT_COUNT_EN.
module player_state #(
  parameter int unsigned X_W        = 4,
  parameter int unsigned X_MAX      = 15,
  parameter int unsigned X_INIT     = 2,
  parameter int unsigned AIM_W      = 3,
  parameter int unsigned AIM_MAX    = 6,
  parameter int unsigned AIM_INIT   = 3,
  parameter int unsigned SHOT_TICKS = 8,
  parameter int unsigned COOLDOWN   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             left_x,
  input  logic             right_x,
  input  logic             left_aim,
  input  logic             right_aim,
  input  logic             shoot_out,
  input  logic [4:0]       select,
  output logic [X_W-1:0]   pos_x,
  output logic [AIM_W-1:0] aim,
  output logic             ready,
  output logic             shot_active,
  output logic [X_W-1:0]   shot_x,
  output logic [AIM_W-1:0] shot_aim,
  output logic [3:0]       shot_step,
  output logic             shot_done,
  output logic [7:0]       shots_fired
);

  localparam int unsigned CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [3:0]  STEP_LAST = 4'(SHOT_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLIGHT, S_COOL, S_NEWGAME} state_e;

  state_e             state_q, state_d;
  logic [X_W-1:0]     pos_q, pos_d;
  logic [AIM_W-1:0]   aim_q, aim_d;
  logic [X_W-1:0]     sx_q, sx_d;
  logic [AIM_W-1:0]   sa_q, sa_d;
  logic [3:0]         step_q, step_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic               active_q, active_d;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               move_ok, aim_ok;

  // Only the new-game bits of the one-hot select gate behaviour.
  logic unused_sel;
  assign unused_sel = ^{select[4:3], select[0]};

`ifdef PLAYER_SHOT_COUNT_EN
  logic [7:0] shots_q, shots_d;
`endif

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    aim_d    = aim_q;
    sx_d     = sx_q;
    sa_d     = sa_q;
    step_d   = step_q;
    done_d   = 1'b0;
    cd_d     = cd_q;
    move_ok  = 1'b0;
    aim_ok   = 1'b0;
`ifdef PLAYER_SHOT_COUNT_EN
    shots_d  = shots_q;
`endif

    if (select[2]) begin
      state_d = S_NEWGAME;
    end else begin
      case (state_q)
        S_IDLE: begin
          move_ok = 1'b1;
          aim_ok  = 1'b1;
          if (shoot_out) begin
            state_d = S_FLIGHT;
            sx_d    = pos_q;
            sa_d    = aim_q;
            step_d  = '0;
`ifdef PLAYER_SHOT_COUNT_EN
            if (shots_q != 8'hFF) shots_d = shots_q + 8'd1;
`endif
          end
        end
        S_FLIGHT: begin
          move_ok = 1'b1;
          if (tick) begin
            if (step_q == STEP_LAST) begin
              state_d = S_COOL;
              done_d  = 1'b1;
              cd_d    = CD_W'(COOLDOWN - 1);
            end else begin
              step_d = step_q + 4'd1;
            end
          end
        end
        S_COOL: begin
          move_ok = 1'b1;
          aim_ok  = 1'b1;
          if (cd_q == '0) state_d = S_IDLE;
          else            cd_d    = cd_q - CD_W'(1);
        end
        default: begin
          if (select[1]) begin
            state_d = S_IDLE;
            pos_d   = X_W'(X_INIT);
            aim_d   = AIM_W'(AIM_INIT);
            sx_d    = '0;
            sa_d    = '0;
            step_d  = '0;
`ifdef PLAYER_SHOT_COUNT_EN
            shots_d = '0;
`endif
          end
        end
      endcase
    end

    // Saturating moves; opposing pulses in the same cycle cancel.
    if (move_ok && (left_x ^ right_x)) begin
      if (left_x) begin
        if (pos_q != '0) pos_d = pos_q - X_W'(1);
      end else if (pos_q != X_W'(X_MAX)) begin
        pos_d = pos_q + X_W'(1);
      end
    end
    if (aim_ok && (left_aim ^ right_aim)) begin
      if (left_aim) begin
        if (aim_q != '0) aim_d = aim_q - AIM_W'(1);
      end else if (aim_q != AIM_W'(AIM_MAX)) begin
        aim_d = aim_q + AIM_W'(1);
      end
    end

    ready_d  = (state_d == S_IDLE);
    active_d = (state_d == S_FLIGHT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pos_q    <= X_W'(X_INIT);
      aim_q    <= AIM_W'(AIM_INIT);
      sx_q     <= '0;
      sa_q     <= '0;
      step_q   <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      cd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      aim_q    <= aim_d;
      sx_q     <= sx_d;
      sa_q     <= sa_d;
      step_q   <= step_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      cd_q     <= cd_d;
    end
  end

`ifdef PLAYER_SHOT_COUNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shots_q <= '0;
    else        shots_q <= shots_d;
  end
  assign shots_fired = shots_q;
`else
  assign shots_fired = 8'd0;
`endif

  assign pos_x       = pos_q;
  assign aim         = aim_q;
  assign ready       = ready_q;
  assign shot_active = active_q;
  assign shot_x      = sx_q;
  assign shot_aim    = sa_q;
  assign shot_step   = step_q;
  assign shot_done   = done_q;

endmodule

// File: tb/tb_player_state.sv
// Scoreboard bench for player_state: directed stimulus queues expected state,
// monitors compare at the falling edge and on every shot_done pulse.
module tb_player_state;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, left_x = 1'b0, right_x = 1'b0;
  logic       left_aim = 1'b0, right_aim = 1'b0, shoot_out = 1'b0;
  logic [4:0] select = 5'd0;
  logic [3:0] pos_x, shot_x, shot_step;
  logic [2:0] aim, shot_aim;
  logic       ready, shot_active, shot_done;
  logic [7:0] shots_fired;

  always #5 clk = ~clk;

  player_state dut (
    .clk(clk), .reset(reset), .tick(tick),
    .left_x(left_x), .right_x(right_x), .left_aim(left_aim), .right_aim(right_aim),
    .shoot_out(shoot_out), .select(select),
    .pos_x(pos_x), .aim(aim), .ready(ready), .shot_active(shot_active),
    .shot_x(shot_x), .shot_aim(shot_aim), .shot_step(shot_step),
    .shot_done(shot_done), .shots_fired(shots_fired)
  );

  typedef struct packed {
    logic [3:0] pos;
    logic [2:0] aim;
    logic       rdy;
    logic       act;
    logic [3:0] sx;
    logic [2:0] sa;
    logic [3:0] step;
    logic       done;
    logic [7:0] shots;
  } exp_t;

  typedef struct packed {
    logic [3:0] sx;
    logic [2:0] sa;
    logic [3:0] step;
  } done_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  e;
  exp_t  exp_q[$];
  string name_q[$];
  done_t done_q[$];

  localparam exp_t RST = '{pos: 4'd2, aim: 3'd3, rdy: 1'b1, act: 1'b0, sx: 4'd0,
                           sa: 3'd0, step: 4'd0, done: 1'b0, shots: 8'd0};

  function automatic logic [7:0] shots_exp(input int n);
`ifdef PLAYER_SHOT_COUNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic drv(input logic tk, lx, rx, la, ra, sh);
    tick = tk; left_x = lx; right_x = rx; left_aim = la; right_aim = ra; shoot_out = sh;
    @(posedge clk); #1;
    tick = 0; left_x = 0; right_x = 0; left_aim = 0; right_aim = 0; shoot_out = 0;
  endtask

  // State monitor: every queued expectation is compared at the next falling edge.
  always @(negedge clk) begin
    exp_t  x, a;
    string nm;
    while (exp_q.size() > 0) begin
      x  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {pos_x, aim, ready, shot_active, shot_x, shot_aim, shot_step, shot_done, shots_fired};
      n_tests++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL %s: got pos=%0d aim=%0d rdy=%0b act=%0b sx=%0d sa=%0d step=%0d done=%0b shots=%0d want pos=%0d aim=%0d rdy=%0b act=%0b sx=%0d sa=%0d step=%0d done=%0b shots=%0d",
                 nm, a.pos, a.aim, a.rdy, a.act, a.sx, a.sa, a.step, a.done, a.shots,
                 x.pos, x.aim, x.rdy, x.act, x.sx, x.sa, x.step, x.done, x.shots);
      end
    end
  end

  // Flight-end monitor: each shot_done pulse must match a queued completed shot.
  always @(negedge clk) begin
    done_t d;
    if (shot_done === 1'b1) begin
      n_tests++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_shot_done: got sx=%0d sa=%0d step=%0d want no pulse",
                 shot_x, shot_aim, shot_step);
      end else begin
        d = done_q.pop_front();
        if ({shot_x, shot_aim, shot_step} !== d) begin
          n_fail++;
          $display("FAIL shot_done_payload: got sx=%0d sa=%0d step=%0d want sx=%0d sa=%0d step=%0d",
                   shot_x, shot_aim, shot_step, d.sx, d.sa, d.step);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    e = RST; chk("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset");

    for (int i = 1; i <= 3; i++) begin
      drv(0, 0, 1, 0, 0, 0); e.pos = 4'(2 + i); chk("move_right");
    end
    for (int i = 1; i <= 20; i++) begin
      drv(0, 1, 0, 0, 0, 0); e.pos = (5 - i > 0) ? 4'(5 - i) : 4'd0; chk("move_left_sat");
    end
    for (int i = 1; i <= 17; i++) begin
      drv(0, 0, 1, 0, 0, 0); e.pos = (i > 15) ? 4'd15 : 4'(i); chk("move_right_sat");
    end
    for (int i = 1; i <= 11; i++) begin
      drv(0, 1, 0, 0, 0, 0); e.pos = 4'(15 - i); chk("move_left");
    end
    for (int i = 1; i <= 5; i++) begin
      drv(0, 0, 0, 0, 1, 0); e.aim = (3 + i > 6) ? 3'd6 : 3'(3 + i); chk("aim_right_sat");
    end
    drv(0, 0, 0, 1, 1, 0); chk("aim_both");
    drv(0, 1, 1, 0, 0, 0); chk("move_both");
    for (int i = 1; i <= 8; i++) begin
      drv(0, 0, 0, 1, 0, 0); e.aim = (6 - i < 0) ? 3'd0 : 3'(6 - i); chk("aim_left_sat");
    end
    for (int i = 1; i <= 5; i++) begin
      drv(0, 0, 0, 0, 1, 0); e.aim = 3'(i); chk("aim_right");
    end

    // Fire with a same-cycle move: shot latches the pre-move position.
    drv(0, 0, 1, 0, 0, 1);
    e.pos = 4'd5; e.rdy = 0; e.act = 1; e.sx = 4'd4; e.sa = 3'd5; e.step = 4'd0;
    e.shots = shots_exp(1); chk("fire");
    done_q.push_back('{sx: 4'd4, sa: 3'd5, step: 4'd7});
    drv(0, 0, 0, 0, 1, 1); chk("flight_ignore_aim_shoot");
    drv(0, 1, 0, 0, 0, 0); e.pos = 4'd4; chk("flight_move");
    for (int i = 1; i <= 8; i++) begin
      drv(1, 0, 0, 0, 0, 0);
      if (i < 8) e.step = 4'(i);
      else begin e.done = 1; e.act = 0; end
      chk("flight_tick");
    end
    e.done = 0;
    for (int c = 1; c <= 16; c++) begin
      case (c)
        2:       drv(0, 0, 0, 0, 0, 1);
        3:       drv(1, 0, 0, 1, 0, 0);
        default: drv(0, 0, 0, 0, 0, 0);
      endcase
      if (c == 3) e.aim = 3'd4;
      e.rdy = (c == 16);
      chk("cooldown");
    end

    // Abort a flight with a new game: no shot_done, state restored.
    drv(0, 0, 0, 0, 0, 1);
    e.rdy = 0; e.act = 1; e.sx = 4'd4; e.sa = 3'd4; e.step = 4'd0;
    e.shots = shots_exp(2); chk("fire2");
    for (int i = 1; i <= 3; i++) begin
      drv(1, 0, 0, 0, 0, 0); e.step = 4'(i); chk("flight2_tick");
    end
    select = 5'b00100;
    drv(1, 0, 1, 0, 1, 0); e.act = 0; chk("newgame_enter");
    drv(0, 1, 0, 1, 0, 1); chk("newgame_hold");
    select = 5'b00110;
    drv(1, 0, 1, 0, 0, 1); chk("newgame_priority");
    select = 5'b00010;
    drv(0, 0, 0, 0, 0, 0); e = RST; chk("newgame_exit");
    select = 5'b11001;
    drv(0, 0, 1, 0, 0, 0); e.pos = 4'd3; chk("select_unused_bits");
    select = 5'b00000;
    drv(0, 1, 0, 0, 0, 0); e.pos = 4'd2; chk("move_back");

    // Async reset in the middle of cooldown.
    drv(0, 0, 0, 0, 0, 1);
    e.rdy = 0; e.act = 1; e.sx = 4'd2; e.sa = 3'd3; e.step = 4'd0;
    e.shots = shots_exp(1); chk("fire3");
    done_q.push_back('{sx: 4'd2, sa: 3'd3, step: 4'd7});
    for (int i = 1; i <= 8; i++) begin
      drv(1, 0, 0, 0, 0, 0);
      if (i < 8) e.step = 4'(i);
      else begin e.done = 1; e.act = 0; end
    end
    chk("flight3_end");
    drv(0, 0, 0, 0, 0, 0); e.done = 0; chk("cooldown3");
    repeat (3) drv(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    e = RST; chk("reset_async");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset2");

    // Long run of accepted shots to exercise counter saturation.
    for (int s = 1; s <= 300; s++) begin
      drv(0, 0, 0, 0, 0, 1);
      done_q.push_back('{sx: 4'd2, sa: 3'd3, step: 4'd7});
      repeat (8) drv(1, 0, 0, 0, 0, 0);
      repeat (16) drv(0, 0, 0, 0, 0, 0);
    end
    e = '{pos: 4'd2, aim: 3'd3, rdy: 1'b1, act: 1'b0, sx: 4'd2, sa: 3'd3,
          step: 4'd7, done: 1'b0, shots: shots_exp(300)};
    chk("shots_sat");

    repeat (2) @(posedge clk);
    n_tests++;
    if (done_q.size() != 0) begin
      n_fail++;
      $display("FAIL shot_done_missing: got %0d pulses outstanding want 0", done_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/player_state.md
Name: player_state

Overview:
- Per-player game state block sitting directly downstream of the input-control stage.
- Consumes that stage's one-cycle action pulses and its one-hot select:
  - left_x / right_x move the tank.
  - left_aim / right_aim adjust the barrel.
  - shoot_out launches a projectile.
  - select bits drive new-game restart.
- Holds tank x position, aim index and the projectile flight/cooldown FSM; outputs feed the renderer and hit logic.

Parameters:
- X_W, 4, width of pos_x and shot_x.
- X_MAX, 15, maximum tank position (inclusive).
- X_INIT, 2, position after reset or new game.
- AIM_W, 3, width of aim and shot_aim.
- AIM_MAX, 6, maximum aim index (inclusive).
- AIM_INIT, 3, aim after reset or new game.
- SHOT_TICKS, 8, tick count of one projectile flight (2..16).
- COOLDOWN, 16, clock cycles between flight end and next allowed shot (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- tick  input  1  frame/step strobe, 1 cycle wide
- left_x  input  1  move-left pulse
- right_x  input  1  move-right pulse
- left_aim  input  1  aim-decrement pulse
- right_aim  input  1  aim-increment pulse
- shoot_out  input  1  fire pulse
- select  input  5  one-hot from control stage; bit2 = new game held, bit1 = delayed new game
- pos_x  output  X_W  current tank position
- aim  output  AIM_W  current aim index
- ready  output  1  high in IDLE (shot may be fired)
- shot_active  output  1  high in FLIGHT
- shot_x  output  X_W  position latched at fire
- shot_aim  output  AIM_W  aim latched at fire
- shot_step  output  4  flight step counter
- shot_done  output  1  one-cycle pulse at flight end
- shots_fired  output  8  see Optional Feature

Behaviour:
- All outputs registered.
- Reset (reset=0, async):
  - State IDLE; pos_x=X_INIT; aim=AIM_INIT.
  - shot_x, shot_aim, shot_step, shot_done, shot_active = 0; ready=1; cooldown counter=0; shots_fired=0.
- States: IDLE, FLIGHT, COOLDOWN, NEWGAME. Encoding is free.
- Movement (IDLE, FLIGHT, COOLDOWN):
  - left_x alone: pos_x-1, saturating at 0.
  - right_x alone: pos_x+1, saturating at X_MAX.
  - Both high: no change.
  - Update visible the cycle after the pulse.
- Aim (IDLE, COOLDOWN only; ignored in FLIGHT):
  - left_aim: aim-1, saturating at 0.
  - right_aim: aim+1, saturating at AIM_MAX.
  - Both high: no change.
- IDLE + shoot_out:
  - Next cycle: FLIGHT; shot_x=pos_x and shot_aim=aim, both taken before any same-cycle move is applied; shot_step=0.
  - A same-cycle move still updates pos_x.
- FLIGHT:
  - shoot_out ignored.
  - Each tick: shot_step+1.
  - Tick with shot_step==SHOT_TICKS-1: shot_done=1 for the next cycle only; go to COOLDOWN; cooldown counter=COOLDOWN-1; shot_step holds its final value.
  - tick does not advance shot_step outside FLIGHT.
- COOLDOWN:
  - Counter decrements every clk, independent of tick.
  - Counter==0: IDLE, so ready rises exactly COOLDOWN cycles after shot_done.
  - shoot_out ignored.
- NEWGAME:
  - select[2]=1 in any state enters NEWGAME next cycle, aborting any flight with no shot_done.
  - While in NEWGAME: all action pulses ignored; ready=0; shot_active=0.
  - Exit when select[2]=0 and select[1]=1: go to IDLE; restore pos_x=X_INIT and aim=AIM_INIT; clear shot_* and shot_step.
  - select[2] has priority over select[1] and over every pulse.
- select[4], select[3], select[0] are not used for gating; the pulses are authoritative.
- ready = (state==IDLE); shot_active = (state==FLIGHT).

Optional Feature:
- Macro PLAYER_SHOT_COUNT_EN.
- Defined:
  - shots_fired increments on each accepted shot (IDLE→FLIGHT), saturating at 255.
  - Cleared by reset and on NEWGAME exit.
- Undefined: shots_fired tied to 0; no counter flops.

Test Plan:
- Reset, then 3 right_x pulses, then 20 left_x pulses → pos_x 2→5, then saturates at 0; aim stays 3.
- 5 right_aim pulses → aim=6 (saturates at AIM_MAX); left_aim and right_aim in the same cycle → aim unchanged.
- pos_x=4, aim=5, shoot_out, 8 ticks → shot_x=4, shot_aim=5; shot_step 0..7; shot_done for 1 cycle; ready=1 exactly 16 clk later.
- shoot_out during FLIGHT and during COOLDOWN → ignored (no relatch, shots_fired unchanged when the macro is defined); right_aim during FLIGHT → aim unchanged.
- Mid-flight: select=00100 for 3 cycles, then 00010 → no shot_done; NEWGAME; then IDLE with pos_x=2, aim=3, shot_step=0, ready=1.
- reset pulled low mid-COOLDOWN → immediate IDLE with reset values; with PLAYER_SHOT_COUNT_EN, 300 accepted shots → shots_fired=255.
